// File: rtl/array_seq_ctrl.sv
// Tile-job sequencer for the rate-coded systolic array: weight load, skewed
// compute strobes per row, and skewed output-drain windows per column.
module array_seq_ctrl #(
    parameter int HEIGHT = 32,
    parameter int WIDTH  = 32,
    parameter int CW     = 10,
    parameter int VW     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CW-1:0]     mac_cycles,
    input  logic [VW-1:0]     n_vec,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [VW-1:0]     vec_idx,
    output logic [HEIGHT-1:0] en_i,
    output logic [HEIGHT-1:0] clr_i,
    output logic [HEIGHT-1:0] mac_done,
    output logic [WIDTH-1:0]  en_w,
    output logic [WIDTH-1:0]  clr_w,
    output logic [WIDTH-1:0]  en_o,
    output logic [WIDTH-1:0]  clr_o
);

    localparam int CNTW = $clog2(2 * HEIGHT + WIDTH);
    localparam logic [CNTW-1:0] LOAD_LAST  = CNTW'(HEIGHT - 1);
    localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(2 * HEIGHT + WIDTH - 2);

    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, FIN} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]     mac_q, mac_d, mc_cfg_q, mc_cfg_d;
    logic [VW-1:0]     vec_q, vec_d, nv_cfg_q, nv_cfg_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [HEIGHT-1:0] en_i_q, en_i_d, clr_i_q, clr_i_d, mac_done_q, mac_done_d;
    logic [HEIGHT-2:0] ext_q, ext_d;
    logic [WIDTH-1:0]  en_w_q, en_w_d, clr_w_q, clr_w_d, en_o_q, en_o_d, clr_o_q, clr_o_d;
    logic              en_b, clr_b, done_b, eno_b, clro_b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mac_d    = mac_q;
        vec_d    = vec_q;
        mc_cfg_d = mc_cfg_q;
        nv_cfg_d = nv_cfg_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (n_vec == '0 || mac_cycles < CW'(HEIGHT)) begin
                        err_d = 1'b1;
                    end else begin
                        mc_cfg_d = mac_cycles;
                        nv_cfg_d = n_vec;
                        cnt_d    = '0;
                        vec_d    = '0;
                        state_d  = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (cnt_q == LOAD_LAST) begin
                    mac_d   = '0;
                    vec_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMPUTE: begin
                if (mac_q == mc_cfg_q - CW'(1)) begin
                    if (vec_q == nv_cfg_q - VW'(1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        mac_d = '0;
                        vec_d = vec_q + 1'b1;
                    end
                end else begin
                    mac_d = mac_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) state_d = FIN;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) state_d = IDLE;

        // Outputs are derived from next-state values so the registered copies line up with state_q.
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        en_w_d  = {WIDTH{state_d == LOAD_W}};
        clr_w_d = {WIDTH{state_d == LOAD_W && cnt_d == '0}};

        en_b   = (state_d == COMPUTE);
        clr_b  = en_b && (mac_d == '0);
        done_b = en_b && (mac_d == mc_cfg_q - CW'(1));

        // The output window opens HEIGHT cycles after row 0's end-of-MAC; ext_q extends the row chain.
        clro_b = mac_done_q[HEIGHT-1];
        eno_b  = mac_done_q[HEIGHT-1] | (|ext_q);

        if (abort) begin
            en_i_d     = '0;
            clr_i_d    = '0;
            mac_done_d = '0;
            ext_d      = '0;
            en_o_d     = '0;
            clr_o_d    = '0;
        end else begin
            en_i_d     = {en_i_q[HEIGHT-2:0], en_b};
            clr_i_d    = {clr_i_q[HEIGHT-2:0], clr_b};
            mac_done_d = {mac_done_q[HEIGHT-2:0], done_b};
            ext_d      = (ext_q << 1) | (HEIGHT-1)'(mac_done_q[HEIGHT-1]);
            en_o_d     = {en_o_q[WIDTH-2:0], eno_b};
            clr_o_d    = {clr_o_q[WIDTH-2:0], clro_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mac_q      <= '0;
            vec_q      <= '0;
            mc_cfg_q   <= '0;
            nv_cfg_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            en_i_q     <= '0;
            clr_i_q    <= '0;
            mac_done_q <= '0;
            ext_q      <= '0;
            en_w_q     <= '0;
            clr_w_q    <= '0;
            en_o_q     <= '0;
            clr_o_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mac_q      <= mac_d;
            vec_q      <= vec_d;
            mc_cfg_q   <= mc_cfg_d;
            nv_cfg_q   <= nv_cfg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            en_i_q     <= en_i_d;
            clr_i_q    <= clr_i_d;
            mac_done_q <= mac_done_d;
            ext_q      <= ext_d;
            en_w_q     <= en_w_d;
            clr_w_q    <= clr_w_d;
            en_o_q     <= en_o_d;
            clr_o_q    <= clr_o_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign vec_idx  = vec_q;
    assign en_i     = en_i_q;
    assign clr_i    = clr_i_q;
    assign mac_done = mac_done_q;
    assign en_w     = en_w_q;
    assign clr_w    = clr_w_q;
    assign en_o     = en_o_q;
    assign clr_o    = clr_o_q;

endmodule
